// File: rtl/note_tone_gen.sv
// Note-code to square-wave speaker driver. Codes 0..24 play C4 plus n semitones,
// codes 25..31 are rest; every code change restarts the waveform from a low phase.
module note_tone_gen #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int DIV_SHIFT = 0,
  parameter int DIV_W     = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] note_in,
  input  logic       mute,
  output logic       spk,
  output logic       tone_active,
  output logic       note_strobe
);

  localparam logic [4:0] LAST_TONE = 5'd24;
  localparam logic [4:0] REST_CODE = 5'd25;

  typedef enum logic {REST, TONE} state_t;

  // Equal-tempered pitches in micro-hertz so the rounding below stays exact in integers.
  function automatic longint unsigned freq_uhz(input int n);
    case (n)
      0:  return 64'd261625565;
      1:  return 64'd277182631;
      2:  return 64'd293664768;
      3:  return 64'd311126984;
      4:  return 64'd329627557;
      5:  return 64'd349228231;
      6:  return 64'd369994423;
      7:  return 64'd391995436;
      8:  return 64'd415304698;
      9:  return 64'd440000000;
      10: return 64'd466163762;
      11: return 64'd493883301;
      12: return 64'd523251131;
      13: return 64'd554365262;
      14: return 64'd587329536;
      15: return 64'd622253967;
      16: return 64'd659255114;
      17: return 64'd698456463;
      18: return 64'd739988845;
      19: return 64'd783990872;
      20: return 64'd830609395;
      21: return 64'd880000000;
      22: return 64'd932327523;
      23: return 64'd987766603;
      24: return 64'd1046502261;
      default: return 64'd0;
    endcase
  endfunction

  // round(CLK_HZ / (2*f)) >> DIV_SHIFT, never below one cycle for a playable code
  function automatic longint unsigned half_calc(input int n);
    longint unsigned f;
    longint unsigned h;
    f = freq_uhz(n);
    if (f == 64'd0) return 64'd0;
    h = ((64'(CLK_HZ) * 64'd1_000_000 + f) / (64'd2 * f)) >> DIV_SHIFT;
    if (h == 64'd0) h = 64'd1;
    return h;
  endfunction

  logic [31:0][DIV_W-1:0] half_tab;

  for (genvar i = 0; i < 32; i++) begin : g_half
    localparam longint unsigned HV = half_calc(i);
    assign half_tab[i] = DIV_W'(HV);
  end

  logic [4:0]       cur_note;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] half;
  logic             change;
  logic             playing;
  logic             wrap;
  state_t           state, state_nxt;

  assign change  = (note_in != cur_note);
  assign playing = (cur_note <= LAST_TONE) && !mute;
  assign half    = half_tab[cur_note];
  assign wrap    = (cnt == half - DIV_W'(1));

  // cur_note always follows note_in, so the next state depends only on the inputs
  always_comb begin
    state_nxt = REST;
    if ((note_in <= LAST_TONE) && !mute) state_nxt = TONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= REST;
    else        state <= state_nxt;
  end

  assign tone_active = (state == TONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_note    <= REST_CODE;
      cnt         <= '0;
      spk         <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      cur_note    <= note_in;
      note_strobe <= change;
      if (change || !playing) begin
        cnt <= '0;
        spk <= 1'b0;
      end else if (wrap) begin
        cnt <= '0;
        spk <= ~spk;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Scoreboarded bench for note_tone_gen at DIV_SHIFT=8: stimulus queues the expected
// strobe / spk-edge events with their cycle numbers, a monitor pops them as they appear.
module tb_note_tone_gen;

  localparam int H0  = 373;  // 95556 >> 8
  localparam int H4  = 296;  // 75843 >> 8
  localparam int H7  = 249;  // 63776 >> 8
  localparam int H9  = 221;  // 56818 >> 8
  localparam int H12 = 186;  // 47778 >> 8

  localparam int EV_STROBE = 0;
  localparam int EV_RISE   = 1;
  localparam int EV_FALL   = 2;

  typedef struct {
    int   kind;
    int   cyc;
    logic ta;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] note_in = 5'd9;
  logic       mute = 1'b0;
  logic       spk, tone_active, note_strobe;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic exp_spk = 1'b0;
  logic prev_spk = 1'b0;
  ev_t  q[$];

  note_tone_gen #(.CLK_HZ(50_000_000), .DIV_SHIFT(8), .DIV_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .note_in(note_in), .mute(mute),
    .spk(spk), .tone_active(tone_active), .note_strobe(note_strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int at, input logic ta);
    ev_t e;
    e.kind = kind; e.cyc = at; e.ta = ta;
    q.push_back(e);
  endtask

  task automatic push_toggle(input int at);
    push(exp_spk ? EV_FALL : EV_RISE, at, 1'b1);
    exp_spk = ~exp_spk;
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind %0d at cyc %0d, queue empty", kind, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.ta !== tone_active) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d ta %0b, want kind %0d cyc %0d ta %0b",
                 kind, cyc, tone_active, e.kind, e.cyc, e.ta);
      end
    end
  endtask

  // Monitor: every strobe and every spk edge must match the head of the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_spk = spk;
    end else begin
      if (note_strobe) check_ev(EV_STROBE);
      if (spk !== prev_spk) check_ev(spk ? EV_RISE : EV_FALL);
      prev_spk = spk;
    end
  end

  // Present a code (also releases reset) at edge t and hold it len cycles.
  task automatic seg(input logic [4:0] code, input logic mute_v, input int half,
                     input logic ta, input int len);
    int t;
    @(negedge clk);
    rst_n = 1'b1; note_in = code; mute = mute_v;
    t = cyc + 1;
    push(EV_STROBE, t, ta);
    if (exp_spk) begin push(EV_FALL, t, ta); exp_spk = 1'b0; end
    if (half > 0 && !mute_v)
      for (int k = half; k < len; k += half) push_toggle(t + k);
    repeat (len - 1) begin
      @(negedge clk);
      if (half == 0 || mute_v) chk("silent", {30'd0, spk, tone_active}, 32'd0);
    end
  endtask

  task automatic mute_on(input int len);
    @(negedge clk);
    mute = 1'b1;
    if (exp_spk) begin push(EV_FALL, cyc + 1, 1'b0); exp_spk = 1'b0; end
    repeat (len - 1) begin
      @(negedge clk);
      chk("muted", {30'd0, spk, tone_active}, 32'd0);
    end
  endtask

  task automatic unmute(input int half, input int len);
    int r;
    @(negedge clk);
    mute = 1'b0;
    r = cyc;
    for (int k = half; k < len; k += half) push_toggle(r + k);
    repeat (len - 2) @(negedge clk);
  endtask

  initial begin
    // reset held with a playable code: everything stays low
    repeat (1000) begin
      @(negedge clk);
      chk("reset", {29'd0, spk, tone_active, note_strobe}, 32'd0);
    end
    seg(5'd9,  1'b0, H9,  1'b1, 700);   // A4 from rest: rise 221, fall 442, rise 663
    seg(5'd12, 1'b0, H12, 1'b1, 500);   // mid-note change while high: drop, then rise 186
    seg(5'd25, 1'b0, 0,   1'b0, 50);    // rest
    seg(5'd30, 1'b0, 0,   1'b0, 50);    // rest to rest still strobes
    seg(5'd0,  1'b0, H0,  1'b1, 400);   // C4, high at end
    mute_on(500);
    unmute(H0, 800);
    seg(5'd4,  1'b1, H4,  1'b0, 50);    // change and mute on the same edge
    unmute(H4, 700);
    seg(5'd7,  1'b0, H7,  1'b1, 300);   // G4, high at end
    // asynchronous reset between clock edges while spk is high
    #2;
    chk("pre_async_spk", {31'd0, spk}, 32'd1);
    rst_n = 1'b0;
    note_in = 5'd4;
    #1;
    chk("async_spk", {31'd0, spk}, 32'd0);
    chk("async_ta", {31'd0, tone_active}, 32'd0);
    exp_spk = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("async_hold", {29'd0, spk, tone_active, note_strobe}, 32'd0);
    end
    seg(5'd4, 1'b0, H4, 1'b1, 700);     // release with code 4 held
    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
